// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bus: ID-stage operand/destination info in; stage enables, forwarding selects and status out.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [4:0]       id_rd;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             idexe_en;
    logic             exemem_en;
    logic             memwb_en;
    logic             idexe_bubble;
    logic             ifid_flush;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;
    logic             tmo_err;

    // Datapath side: supplies ID info, consumes control.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rd,
               branch_taken, mem_busy,
        input  pc_en, ifid_en, idexe_en, exemem_en, memwb_en, idexe_bubble,
               ifid_flush, fwda, fwdb, stall_cnt, tmo_err
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rd,
               branch_taken, mem_busy,
        output pc_en, ifid_en, idexe_en, exemem_en, memwb_en, idexe_bubble,
               ifid_flush, fwda, fwdb, stall_cnt, tmo_err
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use stall,
// memory-busy freeze, stall-cycle statistics and a sticky busy timeout.
// Enables and selects are combinational so a hazard is resolved in the cycle it appears.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO   = 255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned BW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

    state_t           state;
    logic             e_wreg, e_m2reg, m_wreg, m_m2reg;
    logic [4:0]       e_rn, m_rn;
    logic [CNT_W-1:0] stall_q;
    logic [BW-1:0]    busy_cnt;
    logic             tmo_q;

    logic             lu;
    logic             pc_en, ifid_en, idexe_en, exemem_en, memwb_en;
    logic             idexe_bubble, ifid_flush;
    logic [1:0]       fwda, fwdb;

    // Nearest producer wins; a load still in EXE has no data yet, so it cannot forward.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       ew, em,
        input logic [4:0] er,
        input logic       mw, mm,
        input logic [4:0] mr
    );
        if (ew && !em && er != 5'd0 && er == src)      return 2'b01;
        else if (mw && !mm && mr != 5'd0 && mr == src) return 2'b10;
        else if (mw && mm && mr != 5'd0 && mr == src)  return 2'b11;
        else                                           return 2'b00;
    endfunction

    // Load-use hazard and operand forwarding from shadow state and the ID instruction.
    always_comb begin
        lu   = e_wreg && e_m2reg && (e_rn != 5'd0) &&
               ((bus.id_use_rs && e_rn == bus.id_rs) || (bus.id_use_rt && e_rn == bus.id_rt));
        fwda = fwd_sel(bus.id_rs, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
        fwdb = fwd_sel(bus.id_rt, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
    end

    // Pipeline enables: reset > mem_busy freeze > load-use bubble > branch flush.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idexe_en     = 1'b1;
        exemem_en    = 1'b1;
        memwb_en     = 1'b1;
        idexe_bubble = 1'b0;
        ifid_flush   = 1'b0;
        if (rst) begin
            ifid_flush = 1'b0;
        end else if (bus.mem_busy) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idexe_en  = 1'b0;
            exemem_en = 1'b0;
            memwb_en  = 1'b0;
        end else if (lu) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idexe_bubble = 1'b1;
        end else begin
            ifid_flush = bus.branch_taken;
        end
    end

    // Mode register, stage shadows, stall statistics and busy watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            e_wreg   <= 1'b0;
            e_m2reg  <= 1'b0;
            e_rn     <= 5'd0;
            m_wreg   <= 1'b0;
            m_m2reg  <= 1'b0;
            m_rn     <= 5'd0;
            stall_q  <= '0;
            busy_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (bus.mem_busy)  state <= FREEZE;
            else if (lu)       state <= STALL;
            else               state <= RUN;

            if (idexe_en) begin
                if (idexe_bubble) begin
                    e_wreg  <= 1'b0;
                    e_m2reg <= 1'b0;
                    e_rn    <= 5'd0;
                end else begin
                    e_wreg  <= bus.id_wreg;
                    e_m2reg <= bus.id_m2reg;
                    e_rn    <= bus.id_rd;
                end
            end
            if (exemem_en) begin
                m_wreg  <= e_wreg;
                m_m2reg <= e_m2reg;
                m_rn    <= e_rn;
            end

            if (!pc_en && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);

            if (bus.mem_busy) begin
                if (busy_cnt != '1)
                    busy_cnt <= busy_cnt + BW'(1);
                if (32'(busy_cnt) + 32'd1 >= TMO)
                    tmo_q <= 1'b1;
            end else if (state == FREEZE) begin
                busy_cnt <= '0;
            end
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.ifid_en      = ifid_en;
    assign bus.idexe_en     = idexe_en;
    assign bus.exemem_en    = exemem_en;
    assign bus.memwb_en     = memwb_en;
    assign bus.idexe_bubble = idexe_bubble;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.fwda         = fwda;
    assign bus.fwdb         = fwdb;
    assign bus.stall_cnt    = stall_q;
    assign bus.tmo_err      = tmo_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic against an in-flight-instruction reference model.
module tb_pipe_ctrl;
    localparam int unsigned CW = 8;
    localparam int unsigned TM = 255;
    localparam int          OW = CW + 12;
    localparam int          SMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) bus();
    pipe_ctrl #(.CNT_W(CW), .TMO(TM)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] rs, rt;
        logic       ur, ut, wr, ld;
        logic [4:0] rd;
        logic       br, mb;
        logic [OW-1:0] exp;
    } vec_t;

    typedef struct {
        logic       w;
        logic       ld;
        logic [4:0] rd;
    } inst_t;

    // Reference model: instructions in flight, [0] = EXE, [1] = MEM.
    inst_t flight[2];
    int    m_scnt;
    int    m_busy;
    bit    m_tmo;

    function automatic logic [OW-1:0] mk(input logic [4:0] en, input logic bub, input logic fl,
                                         input logic [1:0] fa, input logic [1:0] fb,
                                         input int sc, input logic tm);
        return {en, bub, fl, fa, fb, CW'(sc), tm};
    endfunction

    function automatic logic [OW-1:0] outs();
        return {bus.pc_en, bus.ifid_en, bus.idexe_en, bus.exemem_en, bus.memwb_en,
                bus.idexe_bubble, bus.ifid_flush, bus.fwda, bus.fwdb, bus.stall_cnt, bus.tmo_err};
    endfunction

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (en5,bub,flush,fwda,fwdb,stall_cnt,tmo)", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                         input logic wr, input logic ld, input logic [4:0] rd,
                         input logic br, input logic mb);
        bus.id_rs = rs;  bus.id_rt = rt;
        bus.id_use_rs = ur;  bus.id_use_rt = ut;
        bus.id_wreg = wr;  bus.id_m2reg = ld;  bus.id_rd = rd;
        bus.branch_taken = br;  bus.mem_busy = mb;
    endtask

    // Source selection: scan youngest producer first; an EXE load has nothing to give yet.
    function automatic logic [1:0] m_src(input logic [4:0] r);
        for (int s = 0; s < 2; s++) begin
            if (flight[s].w && flight[s].rd != 5'd0 && flight[s].rd == r) begin
                if (s == 0 && !flight[s].ld) return 2'b01;
                if (s == 1) return flight[s].ld ? 2'b11 : 2'b10;
            end
        end
        return 2'b00;
    endfunction

    function automatic bit m_hazard();
        return flight[0].w && flight[0].ld && flight[0].rd != 5'd0 &&
               ((bus.id_use_rs && flight[0].rd == bus.id_rs) ||
                (bus.id_use_rt && flight[0].rd == bus.id_rt));
    endfunction

    task automatic m_reset();
        flight[0] = '{1'b0, 1'b0, 5'd0};
        flight[1] = '{1'b0, 1'b0, 5'd0};
        m_scnt = 0; m_busy = 0; m_tmo = 1'b0;
    endtask

    function automatic logic [OW-1:0] m_expect();
        logic [4:0] en;
        logic bub, fl;
        en = 5'h1f; bub = 1'b0; fl = 1'b0;
        if (rst) begin
            en = 5'h1f;
        end else if (bus.mem_busy) begin
            en = 5'h00;
        end else if (m_hazard()) begin
            en = 5'b00111; bub = 1'b1;
        end else begin
            fl = bus.branch_taken;
        end
        return mk(en, bub, fl, m_src(bus.id_rs), m_src(bus.id_rt), m_scnt, m_tmo);
    endfunction

    // One clock of model time using the inputs presented this cycle.
    task automatic m_step();
        bit haz;
        haz = !bus.mem_busy && m_hazard();
        if (bus.mem_busy || haz) m_scnt = sat(m_scnt + 1);
        if (bus.mem_busy) begin
            m_busy++;
            if (m_busy >= TM) m_tmo = 1'b1;
        end else begin
            m_busy = 0;
            flight[1] = flight[0];
            flight[0] = haz ? '{1'b0, 1'b0, 5'd0} : '{bus.id_wreg, bus.id_m2reg, bus.id_rd};
        end
    endtask

    vec_t tbl[9];
    int   burst;

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // rs rt ur ut wr ld rd br mb | en bub fl fa fb scnt tmo
        tbl[0] = '{5'd1, 5'd2, 1, 1, 1, 0, 5'd3, 0, 0, mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0)};
        tbl[1] = '{5'd3, 5'd4, 1, 1, 0, 0, 5'd0, 0, 0, mk(5'h1f, 0, 0, 2'b01, 2'b00, 0, 0)};
        tbl[2] = '{5'd3, 5'd3, 1, 1, 0, 0, 5'd0, 0, 0, mk(5'h1f, 0, 0, 2'b10, 2'b10, 0, 0)};
        tbl[3] = '{5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0, mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0)};
        tbl[4] = '{5'd1, 5'd5, 1, 1, 1, 0, 5'd6, 0, 0, mk(5'b00111, 1, 0, 2'b00, 2'b00, 0, 0)};
        tbl[5] = '{5'd1, 5'd5, 1, 1, 1, 0, 5'd6, 0, 0, mk(5'h1f, 0, 0, 2'b00, 2'b11, 1, 0)};
        tbl[6] = '{5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 1, 0, mk(5'h1f, 0, 1, 2'b00, 2'b00, 1, 0)};
        tbl[7] = '{5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 0, mk(5'h1f, 0, 0, 2'b00, 2'b00, 1, 0)};
        tbl[8] = '{5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 0, 0, mk(5'h1f, 0, 0, 2'b00, 2'b00, 1, 0)};

        // Reset dominates a busy memory and a taken branch.
        rst = 1'b1;
        drive(5'd3, 5'd3, 1, 1, 1, 1, 5'd3, 1, 1);
        @(negedge clk);
        chk("reset_outputs", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Forwarding, load-use and r0 vectors.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].ut, tbl[i].wr, tbl[i].ld,
                  tbl[i].rd, tbl[i].br, tbl[i].mb);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
            @(posedge clk); #1;
        end

        // Busy for three cycles over a load-use and taken branch, then the bubble, then the branch.
        drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd5, 0, 0);
        @(negedge clk);
        chk("lf_load", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 1, 0));
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) begin
            drive(5'd5, 5'd7, 1, 1, 0, 0, 5'd0, 1, 1);
            @(negedge clk);
            chk($sformatf("lf_freeze%0d", k), outs(), mk(5'h00, 0, 0, 2'b00, 2'b00, k, 0));
            @(posedge clk); #1;
        end
        drive(5'd5, 5'd7, 1, 1, 0, 0, 5'd0, 1, 0);
        @(negedge clk);
        chk("lf_stall", outs(), mk(5'b00111, 1, 0, 2'b00, 2'b00, 4, 0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lf_run", outs(), mk(5'h1f, 0, 1, 2'b11, 2'b00, 5, 0));
        @(posedge clk); #1;

        // Timeout boundary and stall counter saturation.
        for (int k = 1; k <= int'(TM); k++) begin
            drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
            @(negedge clk);
            if (k == 100 || k == int'(TM))
                chk($sformatf("tmo_busy%0d", k), outs(), mk(5'h00, 0, 0, 2'b00, 2'b00, sat(5 + k - 1), 0));
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0);
            @(negedge clk);
            if (k == 0 || k == 3)
                chk($sformatf("tmo_sticky%0d", k), outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, SMAX, 1));
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a freeze.
        drive(5'd2, 5'd2, 1, 1, 0, 0, 5'd0, 1, 1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_freeze", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(5'd2, 5'd2, 1, 1, 0, 0, 5'd0, 0, 0);
        @(negedge clk);
        chk("post_rst_freeze", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a load-use stall.
        drive(5'd0, 5'd0, 0, 0, 1, 1, 5'd4, 0, 0);
        @(posedge clk); #1;
        drive(5'd4, 5'd1, 1, 0, 0, 0, 5'd0, 0, 0);
        #1;
        chk("pre_rst_stall", outs(), mk(5'b00111, 1, 0, 2'b00, 2'b00, 0, 0));
        rst = 1'b1;
        #1;
        chk("async_rst_stall", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", outs(), mk(5'h1f, 0, 0, 2'b00, 2'b00, 0, 0));
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        rst = 1'b1;
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = int'(TM) + $urandom_range(0, 6);
            rst = ($urandom_range(0, 599) == 0);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  (burst > 0) || ($urandom_range(0, 7) == 0));
            if (burst > 0) burst--;
            if (rst) m_reset();
            @(negedge clk);
            chk($sformatf("rand%0d", c), outs(), m_expect());
            @(posedge clk);
            if (!rst) m_step();
            #1;
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of stall-cycle counter.
REQ-002 Parameter: TMO, 255, max consecutive mem_busy cycles before timeout error.
REQ-003 Ports, clock and reset first; reset is asynchronous and active-high:
  clk  in  1  pipeline clock, all state on posedge;
  rst  in  1  asynchronous active-high reset;
  id_rs, id_rt  in  5  source register numbers of the instruction in ID;
  id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt;
  id_wreg, id_m2reg  in  1  ID instruction writes a register / loads from memory;
  id_rd  in  5  destination register number of the ID instruction;
  branch_taken  in  1  branch/jump resolved taken in ID;
  mem_busy  in  1  data memory not ready, pipeline must hold;
  pc_en, ifid_en, idexe_en, exemem_en, memwb_en  out  1  pipeline register load enables;
  idexe_bubble  out  1  force wreg/m2reg/wmem to 0 on the ID/EXE load;
  ifid_flush  out  1  clear IF/ID on its next load;
  fwda, fwdb  out  2  operand source: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data;
  stall_cnt  out  CNT_W  stall+freeze cycle count;
  tmo_err  out  1  sticky mem_busy timeout flag.

Function
REQ-004 Internal shadow regs SHALL track EXE (e_wreg, e_m2reg, e_rn) and MEM (m_wreg, m_m2reg, m_rn) stage destination info.
REQ-005 On a cycle with idexe_en=1, EXE shadow SHALL load {id_wreg, id_m2reg, id_rd}, or zeros if idexe_bubble=1; MEM shadow SHALL load EXE shadow when exemem_en=1.
REQ-006 fwda SHALL be: 01 if e_wreg & !e_m2reg & e_rn!=0 & e_rn==id_rs; else 10 if m_wreg & !m_m2reg & m_rn!=0 & m_rn==id_rs; else 11 if m_wreg & m_m2reg & m_rn!=0 & m_rn==id_rs; else 00. fwdb identical on id_rt. Combinational from shadow state and ID inputs.
REQ-007 Register 0 SHALL never forward or cause a stall.
REQ-008 Load-use hazard lu = e_wreg & e_m2reg & e_rn!=0 & ((id_use_rs & e_rn==id_rs) | (id_use_rt & e_rn==id_rt)).
REQ-009 FSM states: RUN, STALL, FREEZE; encoding free.
REQ-010 RUN: mem_busy=1 -> FREEZE; else lu=1 -> STALL; else stay RUN.
REQ-011 In RUN without hazard all enables SHALL be 1, idexe_bubble=0, ifid_flush=branch_taken.
REQ-012 STALL (one cycle, entered after lu): pc_en=ifid_en=0, idexe_en=exemem_en=memwb_en=1, idexe_bubble=1, ifid_flush=0; next state RUN (or FREEZE if mem_busy).
REQ-013 The lu condition SHALL also be applied combinationally in the same cycle it appears (RUN outputs take STALL values), so the bubble is inserted without an extra cycle; the STALL state then re-evaluates lu for the next cycle.
REQ-014 FREEZE: all five enables 0, idexe_bubble=0, ifid_flush=0, shadow regs hold; exit to RUN on first cycle with mem_busy=0.
REQ-015 Priority: mem_busy > load-use stall > branch_taken; branch_taken during stall or freeze SHALL be ignored (ID re-evaluates it).
REQ-016 stall_cnt SHALL increment by 1 each cycle pc_en=0 and saturate at all-ones.
REQ-017 A busy counter SHALL count consecutive FREEZE cycles; reaching TMO SHALL set tmo_err, which stays 1 until reset; counter clears on FREEZE exit.

Reset
REQ-018 rst=1 SHALL immediately force state RUN, all shadow regs 0, stall_cnt 0, busy counter 0, tmo_err 0.
REQ-019 During reset outputs SHALL be: all enables 1, idexe_bubble 0, ifid_flush 0, fwda=fwdb=00.
REQ-020 Reset asserted mid-STALL or mid-FREEZE SHALL abandon it with no residual stall after release.

Verification
REQ-021 ALU write r3 then read r3 next instruction -> fwda=01 that cycle; one instruction later -> fwda=10; no stall.
REQ-022 Load r5 then use r5 as rt -> one cycle pc_en=ifid_en=0, idexe_bubble=1, stall_cnt +1; next cycle fwdb=11.
REQ-023 Load to r0 followed by use of r0 -> no stall, fwda=fwdb=00.
REQ-024 mem_busy high 3 cycles coincident with load-use and branch_taken -> 3 cycles all enables 0, then load-use stall, branch_taken ignored until RUN; stall_cnt +4.
REQ-025 mem_busy held TMO cycles -> tmo_err=1, stays 1 after mem_busy drops; rst pulse -> tmo_err=0, stall_cnt=0.
REQ-026 rst asserted asynchronously during FREEZE -> outputs reach reset values before next clk edge.
